// File: rtl/div_seq_r2_pkg.sv
// div_seq_r2_pkg: shared state encodings and default width for the radix-2 divider
package div_seq_r2_pkg;
  localparam int DIV_WIDTH = 32;
  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_CALC = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;
endpackage

// File: rtl/div_seq_r2_step.sv
// div_seq_r2_step: one restoring step, shift {r,q} left and try subtracting the divisor
module div_seq_r2_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] r_n,
  output logic [WIDTH-1:0] q_n
);
  logic [WIDTH:0] rs;
  logic [WIDTH:0] t;
  // r < d <= 2^(WIDTH-1) keeps the shifted remainder below 2^WIDTH, so the borrow bit is the sign
  assign rs  = {r, q[WIDTH-1]};
  assign t   = rs - {1'b0, d};
  assign r_n = t[WIDTH] ? rs[WIDTH-1:0] : t[WIDTH-1:0];
  assign q_n = {q[WIDTH-2:0], ~t[WIDTH]};
endmodule

// File: rtl/div_seq_r2.sv
// div_seq_r2: iterative radix-2 restoring divider returning {remainder, quotient}
module div_seq_r2
  import div_seq_r2_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               valid,
  input  logic               sign,
  output logic               ready,
  output logic [2*WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH) + 1;
  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             sa, sb, bz;
  logic [WIDTH-1:0] r, q, bm;
  logic [WIDTH-1:0] r_n, q_n;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] quo_f, rem_f;
  logic             last;
  assign a_mag = (sign & a[WIDTH-1]) ? -a : a;
  assign b_mag = (sign & b[WIDTH-1]) ? -b : b;
  assign last  = cnt == CW'(WIDTH - 1);
  // divide by zero reports an all-ones quotient regardless of operand signs
  assign quo_f = bz ? '1 : (sa ^ sb) ? -q_n : q_n;
  assign rem_f = sa ? -r_n : r_n;
  assign ready = state == DIV_DONE;
  div_seq_r2_step #(.WIDTH(WIDTH)) u_step (
    .r(r),
    .q(q),
    .d(bm),
    .r_n(r_n),
    .q_n(q_n)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= DIV_IDLE;
      cnt    <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      bz     <= 1'b0;
      r      <= '0;
      q      <= '0;
      bm     <= '0;
      result <= '0;
    end else if (flush) begin
      state <= DIV_IDLE;
    end else if (state == DIV_IDLE) begin
      if (valid) begin
        state <= DIV_CALC;
        sa    <= sign & a[WIDTH-1];
        sb    <= sign & b[WIDTH-1];
        bz    <= b == '0;
        r     <= '0;
        q     <= a_mag;
        bm    <= b_mag;
        cnt   <= '0;
      end
    end else if (state == DIV_CALC) begin
      r   <= r_n;
      q   <= q_n;
      cnt <= cnt + 1'b1;
      if (last) begin
        result <= {rem_f, quo_f};
        state  <= DIV_DONE;
      end
    end else begin
      state <= DIV_IDLE;
    end
  end
endmodule

// File: tb/tb_div_seq_r2.sv
// tb_div_seq_r2: directed vectors with a queue scoreboard checked by a ready monitor
module tb_div_seq_r2;
  typedef struct {
    logic [63:0] res;
    int          cyc;
  } exp_t;
  logic        clk = 0, rst = 1, flush = 0, valid = 0, sign = 0;
  logic [31:0] a = 0, b = 0;
  logic        ready;
  logic [63:0] result;
  exp_t        sbq[$];
  exp_t        e;
  int          cyc = 0, vectors = 0, errors = 0;
  logic        prev_ready = 0;

  div_seq_r2 dut (
    .clk(clk), .rst(rst), .flush(flush), .a(a), .b(b),
    .valid(valid), .sign(sign), .ready(ready), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (prev_ready) check("ready_width", {63'b0, ready}, 64'd0);
    if (ready === 1'b1) begin
      if (sbq.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_ready: got result %h at cycle %0d want no ready", result, cyc);
      end else begin
        e = sbq.pop_front();
        check("result", result, e.res);
        check("latency", 64'(cyc), 64'(e.cyc));
      end
    end
    prev_ready = ready;
  end

  task automatic start(input logic [31:0] aa, input logic [31:0] bb, input logic s,
                       input logic [63:0] exp, input logic push);
    @(negedge clk);
    a = aa;
    b = bb;
    sign = s;
    valid = 1;
    if (push) sbq.push_back('{exp, cyc + 33});
    @(negedge clk);
    valid = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      vectors++;
      errors++;
      $display("FAIL timeout: got %0d pending results want 0", sbq.size());
      sbq.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    check("reset_ready", {63'b0, ready}, 64'd0);
    check("reset_result", result, 64'd0);
    rst = 0;
    start(32'd100, 32'd7, 0, {32'd2, 32'd14}, 1); wait_idle();
    start(32'hFFFFFFF9, 32'd2, 1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1); wait_idle();
    start(32'd7, 32'hFFFFFFFE, 1, {32'd1, 32'hFFFFFFFD}, 1); wait_idle();
    start(32'h80000000, 32'hFFFFFFFF, 1, {32'h0, 32'h80000000}, 1); wait_idle();
    start(32'hFFFFFFFF, 32'd1, 0, {32'h0, 32'hFFFFFFFF}, 1); wait_idle();
    start(32'd100, 32'd7, 1, {32'd2, 32'd14}, 1); wait_idle();
    start(32'd5, 32'd0, 1, {32'd5, 32'hFFFFFFFF}, 1); wait_idle();
    start(32'd5, 32'd0, 0, {32'd5, 32'hFFFFFFFF}, 1); wait_idle();
    // flush mid-calculation, then restart one cycle later
    start(32'd77, 32'd3, 0, 64'd0, 0);
    repeat (9) @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    check("flush_hold", result, {32'd5, 32'hFFFFFFFF});
    a = 32'd100;
    b = 32'd7;
    sign = 0;
    valid = 1;
    sbq.push_back('{{32'd2, 32'd14}, cyc + 33});
    @(negedge clk);
    valid = 0;
    wait_idle();
    // a second valid during CALC must not disturb the in-flight operands
    start(32'd20, 32'd3, 0, {32'd2, 32'd6}, 1);
    repeat (4) @(negedge clk);
    a = 32'd9;
    b = 32'd2;
    valid = 1;
    @(negedge clk);
    valid = 0;
    wait_idle();
    start(32'd100, 32'd7, 0, 64'd0, 0);
    repeat (10) @(negedge clk);
    rst = 1;
    #1;
    check("rst_mid_ready", {63'b0, ready}, 64'd0);
    check("rst_mid_result", result, 64'd0);
    @(negedge clk);
    rst = 0;
    repeat (40) @(negedge clk);
    start(32'd1000, 32'd9, 0, {32'd1, 32'd111}, 1); wait_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
